// File: rtl/fwd_layer_engine.sv
// rtl/fwd_layer_engine.sv - fully-connected layer forward pass: MAC over dual-port memory, saturate, optional ReLU
module fwd_layer_engine #(
  parameter int DWIDTH = 32,
  parameter int FRAC   = 24,
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              act_mode,
  input  logic [AWIDTH-1:0] in_base,
  input  logic [AWIDTH-1:0] w_base,
  input  logic [AWIDTH-1:0] out_base,
  output logic              rd_en,
  output logic [AWIDTH-1:0] rd_addr1,
  output logic [AWIDTH-1:0] rd_addr2,
  input  logic [DWIDTH-1:0] rd_data1,
  input  logic [DWIDTH-1:0] rd_data2,
  output logic              wr_en,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam int PW   = 2 * DWIDTH;
  localparam int ACCW = PW + $clog2(N_IN) + 1;
  localparam int IW   = $clog2(N_IN) + 1;
  localparam int JW   = $clog2(N_OUT) + 1;
  localparam logic signed [ACCW-1:0] MAXV = ACCW'({1'b0, {(DWIDTH-1){1'b1}}});
  localparam logic signed [ACCW-1:0] MINV = -MAXV - 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;
  state_t state, state_nx;

  logic [IW-1:0]           i_cnt;
  logic [JW-1:0]           j_cnt;
  logic [AWIDTH-1:0]       in_base_q, out_base_q, w_ptr;
  logic                    act_q, rd_en_q;
  logic signed [ACCW-1:0]  acc, shifted;
  logic signed [PW-1:0]    prod;
  logic [AWIDTH-1:0]       wr_addr_q;
  logic [DWIDTH-1:0]       wr_data_q, res;

  assign prod    = PW'($signed(rd_data1)) * PW'($signed(rd_data2));
  assign shifted = acc >>> FRAC;

  always_comb begin
    res = shifted[DWIDTH-1:0];
    if (shifted > MAXV)
      res = MAXV[DWIDTH-1:0];
    else if (shifted < MINV)
      res = MINV[DWIDTH-1:0];
    if (act_q && res[DWIDTH-1])
      res = '0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_READ;
      S_READ:  if (i_cnt == IW'(N_IN - 1)) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_WRITE;
      S_WRITE: state_nx = (j_cnt == JW'(N_OUT - 1)) ? S_DONE : S_READ;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      i_cnt      <= '0;
      j_cnt      <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      w_ptr      <= '0;
      act_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      acc        <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state   <= state_nx;
      rd_en_q <= (state == S_READ);
      // Memory data lags the read strobe by one cycle, so accumulate on the delayed strobe.
      if (rd_en_q)
        acc <= acc + ACCW'(prod);
      case (state)
        S_IDLE: if (start) begin
          act_q      <= act_mode;
          in_base_q  <= in_base;
          out_base_q <= out_base;
          w_ptr      <= w_base;
          i_cnt      <= '0;
          j_cnt      <= '0;
          acc        <= '0;
        end
        S_READ: begin
          // Weights are row-major and contiguous, so one running pointer covers every neuron.
          w_ptr <= w_ptr + 1'b1;
          i_cnt <= (i_cnt == IW'(N_IN - 1)) ? '0 : i_cnt + 1'b1;
        end
        S_WRITE: begin
          wr_addr_q <= out_base_q + AWIDTH'(j_cnt);
          wr_data_q <= res;
          j_cnt     <= j_cnt + 1'b1;
          acc       <= '0;
        end
        S_DONE: j_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign rd_en    = (state == S_READ);
  assign rd_addr1 = in_base_q + AWIDTH'(i_cnt);
  assign rd_addr2 = w_ptr;
  assign wr_en    = (state == S_WRITE);
  assign wr_addr  = wr_en ? (out_base_q + AWIDTH'(j_cnt)) : wr_addr_q;
  assign wr_data  = wr_en ? res : wr_data_q;
  assign busy     = (state == S_READ) || (state == S_DRAIN) || (state == S_WRITE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_fwd_layer_engine.sv
// tb/tb_fwd_layer_engine.sv - randomized and directed bench for fwd_layer_engine against an arithmetic layer model
module tb_fwd_layer_engine;
  localparam int N_IN   = 4;
  localparam int N_OUT  = 2;
  localparam int PERIOD = N_IN + 2;
  localparam int LAST   = N_OUT * PERIOD;

  logic        clk = 1'b0;
  logic        rst, start, act_mode;
  logic [7:0]  in_base, w_base, out_base, rd_addr1, rd_addr2, wr_addr;
  logic [31:0] rd_data1, rd_data2, wr_data;
  logic        rd_en, wr_en, busy, done;

  logic [31:0] mem [256];
  logic [31:0] last_wr;
  int          n_pass, n_chk;

  always #5 clk = ~clk;

  fwd_layer_engine #(.DWIDTH(32), .FRAC(24), .N_IN(N_IN), .N_OUT(N_OUT), .AWIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .act_mode(act_mode),
    .in_base(in_base), .w_base(w_base), .out_base(out_base),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data1 <= mem[rd_addr1];
      rd_data2 <= mem[rd_addr2];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // y[j] = sat(floor(sum_i x[i]*w[j][i] / 2^24)), then ReLU if requested
  function automatic logic [31:0] model_y(int j, logic [7:0] inb, logic [7:0] wb, bit act);
    logic signed [127:0] s, r;
    longint a, b;
    logic [31:0] y;
    s = '0;
    for (int i = 0; i < N_IN; i++) begin
      a = longint'($signed(mem[8'(inb + i)]));
      b = longint'($signed(mem[8'(wb + j * N_IN + i)]));
      s = s + 128'(a * b);
    end
    r = s >>> 24;
    if (r > 128'sh7FFFFFFF) y = 32'h7FFFFFFF;
    else if (r < -128'sh80000000) y = 32'h80000000;
    else y = r[31:0];
    if (act && y[31]) y = '0;
    return y;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_wr = '0;
  endtask

  task automatic set_vec(input logic [7:0] base, input logic [31:0] a, b, c, d);
    mem[base] = a; mem[8'(base + 1)] = b; mem[8'(base + 2)] = c; mem[8'(base + 3)] = d;
  endtask

  task automatic run_pass(input bit act, input logic [7:0] inb, wb, outb,
                          input int start_at, input int rst_at);
    logic [31:0] ey [N_OUT];
    logic [31:0] sentinel [N_OUT];
    int jj, p;
    bit aborted, erd, ewr;
    for (int j = 0; j < N_OUT; j++) begin
      ey[j] = model_y(j, inb, wb, act);
      sentinel[j] = 32'hA5A50000 + 32'(j);
      mem[8'(outb + j)] = sentinel[j];
    end
    @(negedge clk);
    act_mode = act; in_base = inb; w_base = wb; out_base = outb; start = 1'b1;
    @(posedge clk);
    aborted = 1'b0;
    for (int c = 1; c <= LAST + 3; c++) begin
      @(negedge clk);
      start = (c == start_at);
      jj = (c - 1) / PERIOD;
      p  = (c - 1) % PERIOD;
      erd = !aborted && jj < N_OUT && p < N_IN;
      ewr = !aborted && jj < N_OUT && p == N_IN + 1;
      chk($sformatf("rd_en c%0d", c), 32'(rd_en), 32'(erd));
      chk($sformatf("wr_en c%0d", c), 32'(wr_en), 32'(ewr));
      chk($sformatf("busy c%0d", c), 32'(busy), 32'(!aborted && c <= LAST));
      chk($sformatf("done c%0d", c), 32'(done), 32'(!aborted && c == LAST + 1));
      if (erd) begin
        chk($sformatf("rd_addr1 c%0d", c), 32'(rd_addr1), 32'(8'(inb + p)));
        chk($sformatf("rd_addr2 c%0d", c), 32'(rd_addr2), 32'(8'(wb + jj * N_IN + p)));
      end
      if (wr_en) begin
        chk($sformatf("wr_addr c%0d", c), 32'(wr_addr), 32'(8'(outb + jj)));
        chk($sformatf("wr_data c%0d", c), wr_data, ey[(jj < N_OUT) ? jj : 0]);
        mem[wr_addr] = wr_data;
        last_wr = wr_data;
      end else begin
        chk($sformatf("wr_hold c%0d", c), wr_data, last_wr);
      end
      if (aborted && rst) rst = 1'b0;
      if (c == rst_at) begin
        rst = 1'b1;
        aborted = 1'b1;
        last_wr = '0;
      end
    end
    for (int j = 0; j < N_OUT; j++)
      chk($sformatf("mem_y%0d", j), mem[8'(outb + j)],
          (rst_at < 0 || (j + 1) * PERIOD <= rst_at) ? ey[j] : sentinel[j]);
  endtask

  initial begin
    logic [7:0] a;
    int sa;
    n_pass = 0; n_chk = 0;
    act_mode = 1'b0; in_base = '0; w_base = '0; out_base = '0;
    for (int k = 0; k < 256; k++) mem[k] = '0;
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_rd_addr", {16'h0, rd_addr1, rd_addr2}, 0);
    do_reset();

    // identity layer, mixed-sign inputs
    set_vec(8'h00, 32'h01000000, 32'h02000000, 32'hFF800000, 32'h00400000);
    set_vec(8'h10, 32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000);
    set_vec(8'h14, 32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000);
    run_pass(1'b0, 8'h00, 8'h10, 8'h20, -1, -1);
    chk("t1_y0", mem[8'h20], 32'h02C00000);
    chk("t1_y1", mem[8'h21], 32'h01600000);

    set_vec(8'h10, 32'hFF000000, 32'hFF000000, 32'hFF000000, 32'hFF000000);
    run_pass(1'b1, 8'h00, 8'h10, 8'h20, -1, -1);
    chk("t2_relu_y0", mem[8'h20], 32'h00000000);
    run_pass(1'b0, 8'h00, 8'h10, 8'h20, -1, -1);
    chk("t2_id_y0", mem[8'h20], 32'hFD400000);

    set_vec(8'h00, 32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h7F000000);
    set_vec(8'h10, 32'h64000000, 32'h64000000, 32'h64000000, 32'h64000000);
    set_vec(8'h14, 32'h9C000000, 32'h9C000000, 32'h9C000000, 32'h9C000000);
    run_pass(1'b0, 8'h00, 8'h10, 8'h20, -1, -1);
    chk("t3_sat_hi", mem[8'h20], 32'h7FFFFFFF);
    chk("t3_sat_lo", mem[8'h21], 32'h80000000);

    set_vec(8'h00, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    set_vec(8'h10, 32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000);
    run_pass(1'b0, 8'h00, 8'h10, 8'h20, -1, -1);
    chk("t4_floor", mem[8'h20], 32'hFFFFFFFF);

    // address wrap on the input vector, with a stray start mid-pass
    set_vec(8'hFE, 32'h01000000, 32'h02000000, 32'hFF800000, 32'h00400000);
    set_vec(8'h10, 32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000);
    set_vec(8'h14, 32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000);
    run_pass(1'b0, 8'hFE, 8'h10, 8'h40, 3, -1);
    chk("t5_y0", mem[8'h40], 32'h02C00000);

    // abort by reset mid-pass, then a clean rerun
    set_vec(8'h00, 32'h01000000, 32'h02000000, 32'hFF800000, 32'h00400000);
    run_pass(1'b0, 8'h00, 8'h10, 8'h20, -1, 8);
    run_pass(1'b0, 8'h00, 8'h10, 8'h20, -1, -1);
    chk("t6_y0", mem[8'h20], 32'h02C00000);
    chk("t6_y1", mem[8'h21], 32'h01600000);

    // random layers at random (wrapping) bases
    for (int t = 0; t < 8; t++) begin
      a = 8'($urandom);
      for (int k = 0; k < N_IN + N_OUT * N_IN; k++) begin
        if ($urandom_range(0, 1) == 1) mem[8'(a + k)] = $urandom;
        else mem[8'(a + k)] = {{8{1'($urandom_range(0, 1))}}, 24'($urandom)};
      end
      case ($urandom_range(0, 2))
        0: sa = -1;
        1: sa = $urandom_range(2, LAST);
        default: sa = LAST + 1;
      endcase
      run_pass(1'($urandom_range(0, 1)), a, 8'(a + N_IN), 8'(a + N_IN + N_OUT * N_IN), sa, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
